instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL provide port clk, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL provide port rst, input, 1, asynchronous active-high reset.
REQ-003 SHALL provide port in_valid, input, 1, field bundle present.
REQ-004 SHALL provide port in_ready, output, 1, encoder accepts bundle this cycle.
REQ-005 SHALL provide ports in_opcode input 4, in_rd input 4 (target/condition reg), in_rs1 input 4, in_rs2 input 4, in_imm input 8 signed (immediate or relative branch offset), in_jaddr input 12 (absolute jump address).
REQ-006 SHALL provide port base_load, input, 1, loads write pointer from base_addr; base_addr, input, 12.
REQ-007 SHALL provide port mem_we, output, 1, instruction write valid; mem_ready, input, 1, memory accepts write.
REQ-008 SHALL provide ports mem_addr output 12, mem_data output 16, program-memory write address and word.
REQ-009 SHALL provide ports err, output, 1, one-cycle pulse on rejected bundle; err_code, output, 2, reason held until next error.
REQ-010 SHALL provide port word_count, output, 13, instructions written since reset/base_load.

Function
REQ-011 Handshake SHALL be: bundle accepted when in_valid && in_ready; write retired when mem_we && mem_ready.
REQ-012 Output stage SHALL be a single holding register; in_ready = !mem_we || mem_ready (full-throughput, no bubble when memory always ready).
REQ-013 Latency SHALL be 1 cycle: accepted bundle appears on mem_we/mem_data/mem_addr the following cycle.
REQ-014 mem_data, mem_addr, mem_we SHALL remain stable while mem_we && !mem_ready.
REQ-015 Encoding, opcode 0 (LI) SHALL be {4'h0, in_rd, in_imm}.
REQ-016 Opcode 1 (UNL) SHALL be {4'h1, in_rd, in_imm}, in_rd used as condition reg.
REQ-017 Opcodes 2..11 (ADD, SUB, AND, OR, NOR, SEQ, SLT, MUL, SHR, FMUL) SHALL be {opcode, in_rd, in_rs1, in_rs2}.
REQ-018 Opcodes 12 (JUMP), 13 (CALL) SHALL be {opcode, in_jaddr}.
REQ-019 Opcode 14 (RET) SHALL be 16'hE000; unused fields ignored.
REQ-020 Opcode 15 SHALL be rejected: err pulses 1 cycle after accept, err_code=2'd1, no write, pointer unchanged.
REQ-021 LI or ALU opcode with in_rd in 10..15 (X, Y, XMINUS, XPLUS, YMINUS, YPLUS; read-only) SHALL be rejected: err_code=2'd2, no write.
REQ-022 Rejected bundles SHALL still be consumed (in_ready handshake completes) and SHALL NOT stall the pipeline.
REQ-023 Write pointer SHALL increment by 1 on each retired write; 12-bit wrap 4095 -> 0.
REQ-024 Write that wraps the pointer to 0 SHALL set err_code=2'd3 with err pulse in the retire cycle; write itself completes.
REQ-025 word_count SHALL increment per retired write, saturating at 4096.
REQ-026 base_load SHALL set pointer=base_addr and word_count=0 next cycle; in_ready SHALL be 0 during the base_load cycle; a pending held write retires at its already-latched address.
REQ-027 Simultaneous retire and accept SHALL place the new word at pointer+1 (address assigned at accept time from a pre-incremented accept pointer).
REQ-028 err_code SHALL hold last error value; err SHALL be a single-cycle pulse per rejected bundle.

Reset
REQ-029 On rst, SHALL asynchronously clear: mem_we=0, mem_addr=0, mem_data=0, pointer=0, word_count=0, err=0, err_code=0; in_ready=1 after deassertion.
REQ-030 rst mid-stall SHALL discard the held write with no further mem_we.

Verification
REQ-031 After reset, ADD rd=1 rs1=2 rs2=3, mem_ready=1 -> next cycle mem_we=1, mem_addr=0, mem_data=16'h2123.
REQ-032 Back-to-back LI rd=5 imm=-1, JUMP 12'hABC, RET -> mem_data 16'h05FF, 16'hCABC, 16'hE000 at addrs 0,1,2 on consecutive cycles; word_count=3.
REQ-033 LI rd=12 imm=4 then opcode 15 -> err pulses twice, err_code 2 then 1, no mem_we, word_count unchanged.
REQ-034 mem_ready=0 for 3 cycles with in_valid held -> in_ready=0, mem_data/mem_addr stable; one write per bundle after release.
REQ-035 base_load base_addr=12'hFFF, write two SUB bundles -> addrs 12'hFFF then 12'h000, err pulse err_code=3 on first retire, word_count=2.
REQ-036 rst asserted while mem_we=1 and mem_ready=0 -> mem_we=0 immediately, pointer=0 after release.

Source files
------------

// File: rtl/instr_encoder_if.sv
// Bundle-in / program-memory-write-out bus for the instruction encoder.
// The master side produces field bundles and models the memory; the slave side is the encoder.
interface instr_encoder_if;
   logic              in_valid;
   logic              in_ready;
   logic [3:0]        in_opcode;
   logic [3:0]        in_rd;
   logic [3:0]        in_rs1;
   logic [3:0]        in_rs2;
   logic signed [7:0] in_imm;
   logic [11:0]       in_jaddr;
   logic              mem_we;
   logic              mem_ready;
   logic [11:0]       mem_addr;
   logic [15:0]       mem_data;

   modport master (
      output in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_imm, in_jaddr, mem_ready,
      input  in_ready, mem_we, mem_addr, mem_data
   );

   modport slave (
      input  in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_imm, in_jaddr, mem_ready,
      output in_ready, mem_we, mem_addr, mem_data
   );
endinterface

// File: rtl/instr_encoder.sv
// Packs decoded instruction fields into 16-bit words and writes them to sequential
// program-memory addresses through a single holding register.
module instr_encoder (
   input  logic           clk,
   input  logic           rst,
   instr_encoder_if.slave bus,
   input  logic           base_load,
   input  logic [11:0]    base_addr,
   output logic           err,
   output logic [1:0]     err_code,
   output logic [12:0]    word_count
);
   localparam logic [3:0]  OP_UNL    = 4'd1;
   localparam logic [3:0]  OP_JUMP   = 4'd12;
   localparam logic [3:0]  OP_RET    = 4'd14;
   localparam logic [3:0]  OP_BAD    = 4'd15;
   localparam logic [3:0]  RD_RO_MIN = 4'd10;
   localparam logic [12:0] CNT_MAX   = 13'd4096;

   logic        mem_we_q, mem_we_d;
   logic [11:0] mem_addr_q, mem_addr_d;
   logic [15:0] mem_data_q, mem_data_d;
   logic [11:0] ptr_q, ptr_d;
   logic [12:0] cnt_q, cnt_d;
   logic        rej_q, rej_d;
   logic [1:0]  err_code_q, err_code_d;

   logic        accept, retire, wrap_now, reject;
   logic [1:0]  rej_code;
   logic [15:0] enc_word;

   assign bus.in_ready = (!mem_we_q || bus.mem_ready) && !base_load;
   assign accept       = bus.in_valid && bus.in_ready;
   assign retire       = mem_we_q && bus.mem_ready;
   assign wrap_now     = retire && (mem_addr_q == 12'hFFF);

   always_comb begin : decode
      enc_word = 16'h0000;
      reject   = 1'b0;
      rej_code = 2'd0;
      if (bus.in_opcode == OP_BAD) begin
         reject   = 1'b1;
         rej_code = 2'd1;
      end else if (bus.in_opcode == OP_RET) begin
         enc_word = 16'hE000;
      end else if (bus.in_opcode >= OP_JUMP) begin
         enc_word = {bus.in_opcode, bus.in_jaddr};
      end else begin
         if (bus.in_opcode <= OP_UNL)
            enc_word = {bus.in_opcode, bus.in_rd, bus.in_imm};
         else
            enc_word = {bus.in_opcode, bus.in_rd, bus.in_rs1, bus.in_rs2};
         // UNL reads rd as a condition, so only LI/ALU targets are write-protected
         if (bus.in_opcode != OP_UNL && bus.in_rd >= RD_RO_MIN) begin
            reject   = 1'b1;
            rej_code = 2'd2;
         end
      end
   end

   always_comb begin : next_state
      mem_we_d   = mem_we_q;
      mem_addr_d = mem_addr_q;
      mem_data_d = mem_data_q;
      ptr_d      = ptr_q;
      cnt_d      = cnt_q;
      rej_d      = accept && reject;
      err_code_d = err_code_q;
      if (retire) begin
         mem_we_d = 1'b0;
         if (cnt_q != CNT_MAX) cnt_d = cnt_q + 13'd1;
      end
      if (base_load) begin
         ptr_d = base_addr;
         cnt_d = 13'd0;
      end
      if (wrap_now) err_code_d = 2'd3;
      // ptr_q is the address of the next accepted word, so it advances at accept time
      if (accept) begin
         if (reject) begin
            err_code_d = rej_code;
         end else begin
            mem_we_d   = 1'b1;
            mem_addr_d = ptr_q;
            mem_data_d = enc_word;
            ptr_d      = ptr_q + 12'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_we_q   <= 1'b0;
         mem_addr_q <= 12'd0;
         mem_data_q <= 16'd0;
         ptr_q      <= 12'd0;
         cnt_q      <= 13'd0;
         rej_q      <= 1'b0;
         err_code_q <= 2'd0;
      end else begin
         mem_we_q   <= mem_we_d;
         mem_addr_q <= mem_addr_d;
         mem_data_q <= mem_data_d;
         ptr_q      <= ptr_d;
         cnt_q      <= cnt_d;
         rej_q      <= rej_d;
         err_code_q <= err_code_d;
      end
   end

   // wrap is flagged while the wrapping write is on the bus, before its code is registered
   assign err          = rej_q || wrap_now;
   assign err_code     = wrap_now ? 2'd3 : err_code_q;
   assign bus.mem_we   = mem_we_q;
   assign bus.mem_addr = mem_addr_q;
   assign bus.mem_data = mem_data_q;
   assign word_count   = cnt_q;
endmodule

// File: tb/tb_instr_encoder.sv
// Randomized and directed bench for instr_encoder, checked every cycle against a
// transaction-level model (queue of pending writes, pointer, counter, error state).
module tb_instr_encoder;
   logic        clk = 1'b0;
   logic        rst;
   logic        base_load;
   logic [11:0] base_addr;
   logic        err;
   logic [1:0]  err_code;
   logic [12:0] word_count;

   instr_encoder_if bus();

   instr_encoder dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus.slave),
      .base_load  (base_load),
      .base_addr  (base_addr),
      .err        (err),
      .err_code   (err_code),
      .word_count (word_count)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // model state: writes accepted but not yet retired, as {addr, data}
   logic [27:0] pend[$];
   int  ptr, cnt, code;
   bit  rej_pend;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      pend.delete();
      ptr = 0; cnt = 0; code = 0; rej_pend = 0;
   endtask

   function automatic int enc(input int op, input int rd, input int rs1, input int rs2,
                              input int imm, input int ja);
      if (op <= 1)       return op * 4096 + rd * 256 + (imm & 255);
      else if (op <= 11) return op * 4096 + rd * 256 + rs1 * 16 + rs2;
      else if (op <= 13) return op * 4096 + ja;
      else               return 'hE000;
   endfunction

   // one clock cycle: drive inputs, check every output against the model, advance the model
   task automatic cyc(input bit v, input int op, input int rd, input int rs1, input int rs2,
                      input int imm, input int ja, input bit mr, input bit bl, input int ba);
      logic [27:0] f;
      logic [11:0] a;
      logic [15:0] w;
      bit exp_ready, retire, wrap;
      @(negedge clk);
      bus.in_valid  = v;
      bus.in_opcode = 4'(op);
      bus.in_rd     = 4'(rd);
      bus.in_rs1    = 4'(rs1);
      bus.in_rs2    = 4'(rs2);
      bus.in_imm    = 8'(imm);
      bus.in_jaddr  = 12'(ja);
      bus.mem_ready = mr;
      base_load     = bl;
      base_addr     = 12'(ba);
      #1;
      f = (pend.size() > 0) ? pend[0] : 28'd0;
      exp_ready = (pend.size() == 0 || mr) && !bl;
      retire    = (pend.size() > 0) && mr;
      wrap      = retire && (f[27:16] == 12'hFFF);
      chk("in_ready", bus.in_ready, exp_ready);
      chk("mem_we", bus.mem_we, pend.size() > 0);
      if (pend.size() > 0) begin
         chk("mem_addr", bus.mem_addr, f[27:16]);
         chk("mem_data", bus.mem_data, f[15:0]);
      end
      chk("err", err, rej_pend || wrap);
      chk("err_code", err_code, wrap ? 3 : code);
      chk("word_count", word_count, cnt);
      if (retire) begin
         void'(pend.pop_front());
         if (cnt < 4096) cnt++;
      end
      if (bl) begin
         ptr = ba % 4096;
         cnt = 0;
      end
      rej_pend = 0;
      if (wrap) code = 3;
      if (v && exp_ready) begin
         if (op == 15) begin
            rej_pend = 1; code = 1;
         end else if ((op == 0 || (op >= 2 && op <= 11)) && rd >= 10) begin
            rej_pend = 1; code = 2;
         end else begin
            a = 12'(ptr);
            w = 16'(enc(op, rd, rs1, rs2, imm, ja));
            pend.push_back({a, w});
            ptr = (ptr + 1) % 4096;
         end
      end
   endtask

   task automatic idle(input bit mr);
      cyc(0, 0, 0, 0, 0, 0, 0, mr, 0, 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      bus.in_valid = 1'b0;
      base_load = 1'b0;
      model_reset();
      #1;
      chk("rst_mem_we", bus.mem_we, 0);
      chk("rst_mem_addr", bus.mem_addr, 0);
      chk("rst_mem_data", bus.mem_data, 0);
      chk("rst_err", err, 0);
      chk("rst_err_code", err_code, 0);
      chk("rst_word_count", word_count, 0);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      bus.in_valid = 1'b0; bus.in_opcode = '0; bus.in_rd = '0; bus.in_rs1 = '0;
      bus.in_rs2 = '0; bus.in_imm = '0; bus.in_jaddr = '0; bus.mem_ready = 1'b1;
      base_load = 1'b0; base_addr = '0;
      model_reset();
      repeat (2) @(posedge clk);
      do_reset();

      // ADD rd=1 rs1=2 rs2=3
      cyc(1, 2, 1, 2, 3, 0, 0, 1, 0, 0);
      idle(1);
      chk("add_we", bus.mem_we, 1);
      chk("add_addr", bus.mem_addr, 0);
      chk("add_data", bus.mem_data, 'h2123);

      // back-to-back LI / JUMP / RET from a fresh reset
      do_reset();
      cyc(1, 0, 5, 0, 0, -1, 0, 1, 0, 0);
      cyc(1, 12, 0, 0, 0, 0, 'hABC, 1, 0, 0);
      chk("li_data", bus.mem_data, 'h05FF);
      chk("li_addr", bus.mem_addr, 0);
      cyc(1, 14, 7, 7, 7, 7, 7, 1, 0, 0);
      chk("jump_data", bus.mem_data, 'hCABC);
      chk("jump_addr", bus.mem_addr, 1);
      idle(1);
      chk("ret_data", bus.mem_data, 'hE000);
      chk("ret_addr", bus.mem_addr, 2);
      idle(1);
      chk("b2b_count", word_count, 3);

      // LI to read-only reg, then opcode 15
      cyc(1, 0, 12, 0, 0, 4, 0, 1, 0, 0);
      cyc(1, 15, 0, 0, 0, 0, 0, 1, 0, 0);
      chk("rej_ro_err", err, 1);
      chk("rej_ro_code", err_code, 2);
      idle(1);
      chk("rej_op_err", err, 1);
      chk("rej_op_code", err_code, 1);
      chk("rej_no_we", bus.mem_we, 0);
      idle(1);
      chk("rej_err_clear", err, 0);
      chk("rej_count", word_count, 3);

      // stall with in_valid held
      cyc(1, 5, 1, 2, 3, 0, 0, 1, 0, 0);
      repeat (3) begin
         cyc(1, 3, 4, 5, 6, 0, 0, 0, 0, 0);
         chk("stall_ready", bus.in_ready, 0);
         chk("stall_data", bus.mem_data, 'h5123);
      end
      cyc(1, 3, 4, 5, 6, 0, 0, 1, 0, 0);
      idle(1);
      chk("stall_data2", bus.mem_data, 'h3456);
      idle(1);
      chk("stall_count", word_count, 5);

      // base_load at the top of memory, two SUBs wrap the pointer
      cyc(0, 0, 0, 0, 0, 0, 0, 1, 1, 'hFFF);
      chk("bl_ready", bus.in_ready, 0);
      cyc(1, 3, 2, 3, 4, 0, 0, 1, 0, 0);
      cyc(1, 3, 4, 5, 6, 0, 0, 1, 0, 0);
      chk("wrap_addr", bus.mem_addr, 'hFFF);
      chk("wrap_err", err, 1);
      chk("wrap_code", err_code, 3);
      idle(1);
      chk("wrap_addr2", bus.mem_addr, 0);
      idle(1);
      chk("wrap_count", word_count, 2);

      // reset while a write is stalled
      cyc(1, 2, 1, 1, 1, 0, 0, 1, 0, 0);
      idle(0);
      #1 rst = 1'b1;
      #1 chk("rst_stall_we", bus.mem_we, 0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      cyc(1, 13, 0, 0, 0, 0, 'h123, 1, 0, 0);
      idle(1);
      chk("rst_stall_addr", bus.mem_addr, 0);

      // randomized traffic, base_load often near the wrap point
      for (int i = 0; i < 3000; i++) begin
         int ba;
         ba = ($urandom_range(0, 1) == 1) ? 4094 + $urandom_range(0, 1) : $urandom_range(0, 4095);
         cyc($urandom_range(0, 9) < 7, $urandom_range(0, 15), $urandom_range(0, 15),
             $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 255),
             $urandom_range(0, 4095), $urandom_range(0, 3) != 0,
             $urandom_range(0, 99) < 3, ba);
      end

      // word_count saturation
      do_reset();
      for (int i = 0; i < 4100; i++) cyc(1, 12, 0, 0, 0, 0, i % 4096, 1, 0, 0);
      idle(1);
      idle(1);
      chk("sat_count", word_count, 4096);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end
endmodule
